// File: rtl/adj_clock_div_arbiter.sv
// adj_clock_div_arbiter: round-robin owner of one adjustable divided clock.
// Ownership only moves on a low ClkOutput so consumers never see a runt.
module adj_clock_div_arbiter #(
  parameter int INPUT_BIT_WIDTH = 8,
  parameter int NUM_REQ         = 4,
  parameter int PERIOD_QUOTA    = 4
) (
  input  logic                               ClkInput,
  input  logic                               Reset,
  input  logic [NUM_REQ-1:0]                 Req,
  input  logic [NUM_REQ*INPUT_BIT_WIDTH-1:0] FactorBus,
  output logic [NUM_REQ-1:0]                 Grant,
  output logic                               Busy,
  output logic                               ClkOutput,
  output logic                               Tick
);
  localparam int W  = INPUT_BIT_WIDTH;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = $clog2(PERIOD_QUOTA + 1);
  localparam logic [PW-1:0] QUOTA = PW'(PERIOD_QUOTA);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [IW-1:0]      win, cand;
  logic [W-1:0]       factor_q, factor_d;
  logic [W-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]      pcnt_q, pcnt_d;
  logic               clk_q, clk_d;
  logic               tick_q, tick_d;
  logic               busy_q;
  logic               found, hit, own_req, other_req;
  logic [W-1:0]       factors [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fac
    assign factors[i] = FactorBus[i*W +: W];
  end

  assign hit       = (cnt_q == factor_q);
  assign own_req   = |(Req & grant_q);
  assign other_req = |(Req & ~grant_q);

  // First requester at or after last owner + 1
  always_comb begin
    found = 1'b0;
    win   = rr_q;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(rr_q) + k) % NUM_REQ);
      if (!found && Req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    factor_d = factor_q;
    cnt_d    = cnt_q;
    pcnt_d   = pcnt_q;
    clk_d    = clk_q;
    tick_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        clk_d = 1'b0;
        cnt_d = '0;
        if (|Req) begin
          state_d       = RUN;
          owner_d       = win;
          grant_d       = '0;
          grant_d[win]  = 1'b1;
          factor_d      = factors[win];
          pcnt_d        = '0;
        end
      end
      RUN, DRAIN: begin
        if (hit) begin
          cnt_d  = '0;
          clk_d  = ~clk_q;
          tick_d = 1'b1;
          if (clk_q && pcnt_q != QUOTA)
            pcnt_d = pcnt_q + PW'(1);
        end else begin
          cnt_d = cnt_q + W'(1);
        end
        if (state_q == RUN) begin
          if (!own_req || (pcnt_q == QUOTA && other_req))
            state_d = DRAIN;
        end else if (!clk_q || hit) begin
          // Release only when ClkOutput ends low this cycle
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
          clk_d   = 1'b0;
          tick_d  = hit && clk_q;
          rr_d    = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ClkInput) begin
    if (Reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_q     <= IW'(NUM_REQ - 1);
      factor_q <= '0;
      cnt_q    <= '0;
      pcnt_q   <= '0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      factor_q <= factor_d;
      cnt_q    <= cnt_d;
      pcnt_q   <= pcnt_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign Grant     = grant_q;
  assign Busy      = busy_q;
  assign ClkOutput = clk_q;
  assign Tick      = tick_q;

endmodule

// File: tb/tb_adj_clock_div_arbiter.sv
// tb_adj_clock_div_arbiter: directed stimulus, expected output events
// queued per test and matched by an independent monitor.
module tb_adj_clock_div_arbiter;
  localparam int W = 8;
  localparam int N = 4;
  localparam int Q = 4;

  typedef struct {
    int         tid;
    int         cyc;
    logic [3:0] g;
    logic       b;
    logic       c;
    logic       t;
  } ev_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] fbus = '0;
  logic [N-1:0]   grant;
  logic           busy, co, tick;

  adj_clock_div_arbiter #(
    .INPUT_BIT_WIDTH(W),
    .NUM_REQ(N),
    .PERIOD_QUOTA(Q)
  ) dut (
    .ClkInput(clk),
    .Reset(rst),
    .Req(req),
    .FactorBus(fbus),
    .Grant(grant),
    .Busy(busy),
    .ClkOutput(co),
    .Tick(tick)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   tid = 0;
  logic mon_en = 1'b0;
  logic [N-1:0] g_prev = '0;
  logic b_prev = 1'b0;
  ev_t  sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: an output event is a Tick pulse or a Grant/Busy change
  always @(negedge clk) begin
    ev_t  e;
    logic ev;
    ev = tick || (grant != g_prev) || (busy != b_prev);
    g_prev = grant;
    b_prev = busy;
    if (mon_en && ev) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event cyc=%0d got g=%b b=%b c=%b t=%b want none",
                 cyc, grant, busy, co, tick);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.g !== grant || e.b !== busy ||
            e.c !== co || e.t !== tick) begin
          bad++;
          $display("FAIL t%0d_event got cyc=%0d g=%b b=%b c=%b t=%b want cyc=%0d g=%b b=%b c=%b t=%b",
                   e.tid, cyc, grant, busy, co, tick, e.cyc, e.g, e.b, e.c, e.t);
        end
      end
    end
  end

  task automatic push(input int c, input logic [3:0] g,
                      input logic b, input logic o, input logic t);
    ev_t e;
    e.tid = tid;
    e.cyc = c;
    e.g = g;
    e.b = b;
    e.c = o;
    e.t = t;
    sb.push_back(e);
  endtask

  // Toggle k of an owner granted at cycle base, half-period hp
  task automatic push_toggles(input int base, input int hp, input int k0,
                              input int k1, input logic [3:0] g);
    for (int k = k0; k <= k1; k++)
      push(base + hp * k, g, 1'b1, (k % 2) == 1, 1'b1);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic set_f(input int i, input logic [W-1:0] v);
    fbus[i*W +: W] = v;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      total += sb.size();
      bad += sb.size();
      $display("FAIL t%0d_drain got left=%0d want left=0", tid, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  initial begin
    int g0;
    int h;
    do_reset();
    total++;
    if (grant !== 4'b0 || busy !== 1'b0 || co !== 1'b0 || tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got g=%b b=%b c=%b t=%b want 0000 0 0 0",
               grant, busy, co, tick);
    end

    // T1: single owner, factor 3 -> toggle every 4 cycles
    tid = 1;
    set_f(0, 8'd3);
    req = 4'b0001;
    g0 = cyc + 1;
    push(g0, 4'b0001, 1'b1, 1'b0, 1'b0);
    push_toggles(g0, 4, 1, 6, 4'b0001);
    wait_drain(200);
    do_reset();

    // T2: quota hand-over from owner 0 (factor 2) to owner 1 (factor 5)
    tid = 2;
    set_f(0, 8'd2);
    set_f(1, 8'd5);
    req = 4'b0011;
    g0 = cyc + 1;
    push(g0, 4'b0001, 1'b1, 1'b0, 1'b0);
    push_toggles(g0, 3, 1, 8, 4'b0001);
    push(g0 + 26, 4'b0000, 1'b0, 1'b0, 1'b0);
    h = g0 + 27;
    push(h, 4'b0010, 1'b1, 1'b0, 1'b0);
    push_toggles(h, 6, 1, 4, 4'b0010);
    wait_drain(300);
    do_reset();

    // T3: owner 2 drops Req while high, then while low
    tid = 3;
    set_f(2, 8'd7);
    req = 4'b0100;
    g0 = cyc + 1;
    push(g0, 4'b0100, 1'b1, 1'b0, 1'b0);
    push(g0 + 8, 4'b0100, 1'b1, 1'b1, 1'b1);
    push(g0 + 16, 4'b0000, 1'b0, 1'b0, 1'b1);
    wait_to(g0 + 10);
    req = 4'b0000;
    wait_to(g0 + 20);
    req = 4'b0100;
    g0 = cyc + 1;
    push(g0, 4'b0100, 1'b1, 1'b0, 1'b0);
    push(g0 + 8, 4'b0100, 1'b1, 1'b1, 1'b1);
    push(g0 + 16, 4'b0100, 1'b1, 1'b0, 1'b1);
    push(g0 + 19, 4'b0000, 1'b0, 1'b0, 1'b0);
    wait_to(g0 + 17);
    req = 4'b0000;
    wait_to(g0 + 25);
    wait_drain(100);
    do_reset();

    // T4: factor extremes 0 and 255
    tid = 4;
    set_f(0, 8'd0);
    req = 4'b0001;
    g0 = cyc + 1;
    push(g0, 4'b0001, 1'b1, 1'b0, 1'b0);
    push_toggles(g0, 1, 1, 6, 4'b0001);
    wait_drain(100);
    do_reset();
    tid = 5;
    set_f(0, 8'd255);
    req = 4'b0001;
    g0 = cyc + 1;
    push(g0, 4'b0001, 1'b1, 1'b0, 1'b0);
    push_toggles(g0, 256, 1, 2, 4'b0001);
    wait_drain(1000);
    do_reset();

    // T5: reset mid-run with ClkOutput high, then full rotation
    tid = 6;
    for (int i = 0; i < N; i++) set_f(i, 8'd1);
    req = 4'b1111;
    g0 = cyc + 1;
    push(g0, 4'b0001, 1'b1, 1'b0, 1'b0);
    push(g0 + 2, 4'b0001, 1'b1, 1'b1, 1'b1);
    push(g0 + 3, 4'b0000, 1'b0, 1'b0, 1'b0);
    h = g0 + 4;
    for (int i = 0; i < N; i++) begin
      push(h + 19 * i, 4'(1 << i), 1'b1, 1'b0, 1'b0);
      push_toggles(h + 19 * i, 2, 1, 8, 4'(1 << i));
      push(h + 19 * i + 18, 4'b0000, 1'b0, 1'b0, 1'b0);
    end
    push(h + 76, 4'b0001, 1'b1, 1'b0, 1'b0);
    wait_to(g0 + 2);
    rst = 1'b1;
    wait_to(g0 + 3);
    rst = 1'b0;
    wait_drain(300);
    do_reset();

    // T6: factor change mid-ownership only applies after re-grant
    tid = 7;
    set_f(0, 8'd3);
    req = 4'b0001;
    g0 = cyc + 1;
    push(g0, 4'b0001, 1'b1, 1'b0, 1'b0);
    push_toggles(g0, 4, 1, 6, 4'b0001);
    wait_to(g0 + 5);
    set_f(0, 8'd9);
    wait_to(g0 + 25);
    req = 4'b0000;
    push(g0 + 27, 4'b0000, 1'b0, 1'b0, 1'b0);
    wait_to(g0 + 29);
    req = 4'b0001;
    h = g0 + 30;
    push(h, 4'b0001, 1'b1, 1'b0, 1'b0);
    push_toggles(h, 10, 1, 2, 4'b0001);
    wait_drain(200);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
